// File: rtl/fc_credit_gate.sv
// Read-request credit gate: round-robin grants read channels only when a tag, TX buffers and
// (optionally) completion header/data credits are available, and tracks per-tag credit usage.
module fc_credit_gate #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned TAG_W        = 5,
  parameter int unsigned CPLH_CREDITS = 36,
  parameter int unsigned CPLD_CREDITS = 154,
  parameter int unsigned TBUF_MIN     = 1,
  parameter int unsigned MAX_RD_DW    = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_rst_i,
  input  logic                rd_metering_i,
  input  logic                cfg_rcb_i,
  input  logic [5:0]          trn_tbuf_av_i,
  input  logic [NUM_CH-1:0]   rd_req_i,
  input  logic [NUM_CH*11-1:0] rd_len_i,
  input  logic [NUM_CH*7-1:0] rd_addr_lo_i,
  output logic [NUM_CH-1:0]   rd_gnt_o,
  output logic [TAG_W-1:0]    rd_gnt_tag_o,
  input  logic                cpl_done_i,
  input  logic [TAG_W-1:0]    cpl_done_tag_i,
  input  logic                mwr_start_i,
  output logic                mwr_start_fc_o,
  output logic [7:0]          cplh_avail_o,
  output logic [11:0]         cpld_avail_o,
  output logic                tag_err_o
);

  localparam int unsigned NumTags = 1 << TAG_W;
  localparam int unsigned PtrW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW    = 16;

  typedef enum logic [0:0] {StIdle, StGnt} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [TAG_W-1:0]    gnt_tag_q, gnt_tag_d;
  logic                mwr_q;
  logic                tag_err_q;
  logic [NumTags-1:0]  tag_busy_q, tag_busy_d;
  logic [7:0]          tag_hdr_q [NumTags];
  logic [8:0]          tag_dat_q [NumTags];
  logic [CntW-1:0]     hdr_used_q, hdr_used_d;
  logic [CntW-1:0]     dat_used_q, dat_used_d;

  logic [CntW-1:0]     hdr_need [NUM_CH];
  logic [CntW-1:0]     dat_need [NUM_CH];
  logic [NUM_CH-1:0]   len_ok;
  logic [NUM_CH-1:0]   elig;
  logic                tbuf_ok;
  logic                free_any;
  logic [TAG_W-1:0]    free_tag;
  logic                alloc;
  logic                rel;
  logic                rel_err;
  logic                found;
  logic [PtrW-1:0]     sel;

  assign tbuf_ok = 32'(trn_tbuf_av_i) > TBUF_MIN;

  // Segment and data-credit needs per channel; length 0 encodes 1024 DW.
  always_comb begin
    logic [10:0] len_raw;
    logic [6:0]  addr;
    logic [12:0] len_dw;
    logic [12:0] bytes;
    logic [12:0] last;
    logic [12:0] hdr;
    logic [12:0] dat;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      len_raw = rd_len_i[c*11 +: 11];
      addr    = rd_addr_lo_i[c*7 +: 7];
      len_dw  = (len_raw == 11'd0) ? 13'd1024 : {2'b00, len_raw};
      bytes   = {len_dw[10:0], 2'b00};
      last    = {6'b0, addr} + bytes - 13'd1;
      if (cfg_rcb_i) hdr = (last >> 7) - ({6'b0, addr} >> 7) + 13'd1;
      else           hdr = (last >> 6) - ({6'b0, addr} >> 6) + 13'd1;
      dat         = ({9'b0, addr[3:0]} + bytes + 13'd15) >> 4;
      hdr_need[c] = CntW'(hdr);
      dat_need[c] = CntW'(dat);
      len_ok[c]   = 32'(len_dw) <= MAX_RD_DW;
    end
  end

  always_comb begin
    free_any = 1'b0;
    free_tag = '0;
    for (int i = NumTags - 1; i >= 0; i--) begin
      if (!tag_busy_q[i]) begin
        free_any = 1'b1;
        free_tag = TAG_W'(i);
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      elig[c] = rd_req_i[c] && free_any && tbuf_ok && len_ok[c] &&
                (!rd_metering_i ||
                 ((hdr_need[c] + hdr_used_q <= CntW'(CPLH_CREDITS)) &&
                  (dat_need[c] + dat_used_q <= CntW'(CPLD_CREDITS))));
    end
  end

  // Round-robin search starting at ptr_q, the channel after the last grant.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(ptr_q) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    gnt_tag_d = '0;
    alloc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StGnt;
          alloc      = 1'b1;
          gnt_d[sel] = 1'b1;
          gnt_tag_d  = free_tag;
          ptr_d      = (sel == PtrW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
        end
      end
      StGnt:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A released tag is still busy this cycle, so free_tag never equals it.
  always_comb begin
    rel        = cpl_done_i && tag_busy_q[cpl_done_tag_i];
    rel_err    = cpl_done_i && !tag_busy_q[cpl_done_tag_i];
    tag_busy_d = tag_busy_q;
    hdr_used_d = hdr_used_q;
    dat_used_d = dat_used_q;
    if (rel) begin
      tag_busy_d[cpl_done_tag_i] = 1'b0;
      hdr_used_d = hdr_used_d - CntW'(tag_hdr_q[cpl_done_tag_i]);
      dat_used_d = dat_used_d - CntW'(tag_dat_q[cpl_done_tag_i]);
    end
    if (alloc) begin
      tag_busy_d[free_tag] = 1'b1;
      hdr_used_d = hdr_used_d + hdr_need[sel];
      dat_used_d = dat_used_d + dat_need[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || init_rst_i) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gnt_q      <= '0;
      gnt_tag_q  <= '0;
      mwr_q      <= 1'b0;
      tag_err_q  <= 1'b0;
      tag_busy_q <= '0;
      hdr_used_q <= '0;
      dat_used_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gnt_tag_q  <= gnt_tag_d;
      mwr_q      <= mwr_start_i && tbuf_ok;
      tag_busy_q <= tag_busy_d;
      hdr_used_q <= hdr_used_d;
      dat_used_q <= dat_used_d;
      if (rel_err) tag_err_q <= 1'b1;
    end
  end

  // Table contents only matter while the busy bit is set, so no reset is needed.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_hdr_q[free_tag] <= 8'(hdr_need[sel]);
      tag_dat_q[free_tag] <= 9'(dat_need[sel]);
    end
  end

  assign rd_gnt_o       = gnt_q;
  assign rd_gnt_tag_o   = gnt_tag_q;
  assign mwr_start_fc_o = mwr_q;
  assign tag_err_o      = tag_err_q;
  assign cplh_avail_o   = 8'(CntW'(CPLH_CREDITS) - hdr_used_q);
  assign cpld_avail_o   = 12'(CntW'(CPLD_CREDITS) - dat_used_q);

endmodule

// File: tb/tb_fc_credit_gate.sv
// Directed bench for fc_credit_gate: single-request vector table plus multi-cycle sequences.
module tb_fc_credit_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_rst_i;
  logic        rd_metering_i;
  logic        cfg_rcb_i;
  logic [5:0]  trn_tbuf_av_i;
  logic [1:0]  rd_req_i;
  logic [21:0] rd_len_i;
  logic [13:0] rd_addr_lo_i;
  logic [1:0]  rd_gnt_o;
  logic [4:0]  rd_gnt_tag_o;
  logic        cpl_done_i;
  logic [4:0]  cpl_done_tag_i;
  logic        mwr_start_i;
  logic        mwr_start_fc_o;
  logic [7:0]  cplh_avail_o;
  logic [11:0] cpld_avail_o;
  logic        tag_err_o;

  int checks = 0;
  int errors = 0;

  fc_credit_gate dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .init_rst_i     (init_rst_i),
    .rd_metering_i  (rd_metering_i),
    .cfg_rcb_i      (cfg_rcb_i),
    .trn_tbuf_av_i  (trn_tbuf_av_i),
    .rd_req_i       (rd_req_i),
    .rd_len_i       (rd_len_i),
    .rd_addr_lo_i   (rd_addr_lo_i),
    .rd_gnt_o       (rd_gnt_o),
    .rd_gnt_tag_o   (rd_gnt_tag_o),
    .cpl_done_i     (cpl_done_i),
    .cpl_done_tag_i (cpl_done_tag_i),
    .mwr_start_i    (mwr_start_i),
    .mwr_start_fc_o (mwr_start_fc_o),
    .cplh_avail_o   (cplh_avail_o),
    .cpld_avail_o   (cpld_avail_o),
    .tag_err_o      (tag_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rcb;
    logic        met;
    logic [5:0]  tbuf;
    logic [10:0] len;
    logic [6:0]  addr;
    logic        exp_gnt;
    int          exp_h;
    int          exp_d;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [10:0] len, input logic [6:0] addr);
    rd_len_i[c*11 +: 11]    = len;
    rd_addr_lo_i[c*7 +: 7]  = addr;
  endtask

  task automatic soft_reset();
    init_rst_i = 1'b1;
    tick();
    init_rst_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 6'd8, 11'd32,  7'h3C, 1'b1, 33, 145};
    vecs[1] = '{1'b1, 1'b1, 6'd8, 11'd32,  7'h3C, 1'b1, 34, 145};
    vecs[2] = '{1'b0, 1'b1, 6'd8, 11'd16,  7'h00, 1'b1, 35, 150};
    vecs[3] = '{1'b0, 1'b1, 6'd8, 11'd1,   7'h7F, 1'b1, 34, 152};
    vecs[4] = '{1'b1, 1'b1, 6'd8, 11'd128, 7'h00, 1'b1, 32, 122};
    vecs[5] = '{1'b0, 1'b1, 6'd1, 11'd1,   7'h00, 1'b0, 36, 154};
    vecs[6] = '{1'b0, 1'b1, 6'd2, 11'd1,   7'h00, 1'b1, 35, 153};
    vecs[7] = '{1'b0, 1'b0, 6'd8, 11'd512, 7'h00, 1'b1, 4,  26};
    vecs[8] = '{1'b1, 1'b1, 6'd8, 11'd512, 7'h7F, 1'b1, 19, 25};

    rst_n = 1'b0; init_rst_i = 1'b0; rd_metering_i = 1'b1; cfg_rcb_i = 1'b0;
    trn_tbuf_av_i = 6'd8; rd_req_i = '0; rd_len_i = '0; rd_addr_lo_i = '0;
    cpl_done_i = 1'b0; cpl_done_tag_i = '0; mwr_start_i = 1'b1;
    tick();
    tick();
    chk("reset gnt", int'(rd_gnt_o), 0);
    chk("reset tag", int'(rd_gnt_tag_o), 0);
    chk("reset mwr", int'(mwr_start_fc_o), 0);
    chk("reset cplh", int'(cplh_avail_o), 36);
    chk("reset cpld", int'(cpld_avail_o), 154);
    chk("reset tag_err", int'(tag_err_o), 0);
    rst_n = 1'b1;

    // Single-request table: one grant from a clean state.
    for (int i = 0; i < 9; i++) begin
      soft_reset();
      cfg_rcb_i = vecs[i].rcb;
      rd_metering_i = vecs[i].met;
      trn_tbuf_av_i = vecs[i].tbuf;
      set_ch(0, vecs[i].len, vecs[i].addr);
      mwr_start_i = 1'b1;
      rd_req_i = 2'b01;
      tick();
      chk($sformatf("v%0d gnt", i), int'(rd_gnt_o), vecs[i].exp_gnt ? 1 : 0);
      chk($sformatf("v%0d tag", i), int'(rd_gnt_tag_o), 0);
      chk($sformatf("v%0d cplh", i), int'(cplh_avail_o), vecs[i].exp_h);
      chk($sformatf("v%0d cpld", i), int'(cpld_avail_o), vecs[i].exp_d);
      chk($sformatf("v%0d mwr", i), int'(mwr_start_fc_o), (vecs[i].tbuf > 1) ? 1 : 0);
      rd_req_i = 2'b00;
      tick();
    end
    mwr_start_i = 1'b0;
    trn_tbuf_av_i = 6'd8;
    cfg_rcb_i = 1'b0;
    rd_metering_i = 1'b1;

    // Round-robin between two continuous requesters.
    soft_reset();
    set_ch(0, 11'd16, 7'h00);
    set_ch(1, 11'd16, 7'h00);
    rd_req_i = 2'b11;
    tick(); chk("rr g0", int'(rd_gnt_o), 1); chk("rr t0", int'(rd_gnt_tag_o), 0);
    tick(); chk("rr idle0", int'(rd_gnt_o), 0);
    tick(); chk("rr g1", int'(rd_gnt_o), 2); chk("rr t1", int'(rd_gnt_tag_o), 1);
    tick(); chk("rr idle1", int'(rd_gnt_o), 0);
    tick(); chk("rr g2", int'(rd_gnt_o), 1); chk("rr t2", int'(rd_gnt_tag_o), 2);
    rd_req_i = 2'b00;
    chk("rr cplh", int'(cplh_avail_o), 33);
    chk("rr cpld", int'(cpld_avail_o), 142);
    tick();

    // Data-credit exhaustion and tag reuse.
    soft_reset();
    set_ch(0, 11'd128, 7'h00);
    rd_req_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("ex g%0d", i), int'(rd_gnt_o), 1);
      chk($sformatf("ex t%0d", i), int'(rd_gnt_tag_o), i);
      tick();
    end
    chk("ex cpld", int'(cpld_avail_o), 26);
    chk("ex cplh", int'(cplh_avail_o), 4);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("ex block%0d", i), int'(rd_gnt_o), 0);
    end
    cpl_done_i = 1'b1; cpl_done_tag_i = 5'd2;
    tick();
    cpl_done_i = 1'b0;
    chk("rel gnt", int'(rd_gnt_o), 0);
    chk("rel cpld", int'(cpld_avail_o), 58);
    chk("rel cplh", int'(cplh_avail_o), 12);
    tick();
    chk("reuse gnt", int'(rd_gnt_o), 1);
    chk("reuse tag", int'(rd_gnt_tag_o), 2);
    chk("reuse cpld", int'(cpld_avail_o), 26);
    rd_req_i = 2'b00;
    tick();

    // Release of a free tag.
    cpl_done_i = 1'b1; cpl_done_tag_i = 5'd5;
    tick();
    cpl_done_i = 1'b0;
    chk("err flag", int'(tag_err_o), 1);
    chk("err cplh", int'(cplh_avail_o), 4);
    chk("err cpld", int'(cpld_avail_o), 26);

    // Grant and release in the same cycle: tags 0..3 busy, release 0, grant ch1.
    set_ch(1, 11'd16, 7'h00);
    rd_req_i = 2'b10;
    cpl_done_i = 1'b1; cpl_done_tag_i = 5'd0;
    tick();
    cpl_done_i = 1'b0;
    rd_req_i = 2'b00;
    chk("both gnt", int'(rd_gnt_o), 2);
    chk("both tag", int'(rd_gnt_tag_o), 4);
    chk("both cplh", int'(cplh_avail_o), 11);
    chk("both cpld", int'(cpld_avail_o), 54);
    chk("both err sticky", int'(tag_err_o), 1);
    tick();

    // Soft re-init with a request and a release pending in the same cycle.
    rd_req_i = 2'b01;
    cpl_done_i = 1'b1; cpl_done_tag_i = 5'd1;
    init_rst_i = 1'b1;
    tick();
    init_rst_i = 1'b0;
    cpl_done_i = 1'b0;
    chk("init gnt", int'(rd_gnt_o), 0);
    chk("init cplh", int'(cplh_avail_o), 36);
    chk("init cpld", int'(cpld_avail_o), 154);
    chk("init tag_err", int'(tag_err_o), 0);
    tick();
    chk("init regnt", int'(rd_gnt_o), 1);
    chk("init retag", int'(rd_gnt_tag_o), 0);
    chk("init cpld2", int'(cpld_avail_o), 122);
    rd_req_i = 2'b00;
    tick();

    // Metering off: only tag exhaustion stops grants.
    soft_reset();
    rd_metering_i = 1'b0;
    set_ch(0, 11'd1, 7'h00);
    rd_req_i = 2'b01;
    for (int i = 0; i < 32; i++) begin
      tick(); chk($sformatf("nm t%0d", i), int'(rd_gnt_tag_o), i);
      chk($sformatf("nm g%0d", i), int'(rd_gnt_o), 1);
      tick();
    end
    chk("nm cplh", int'(cplh_avail_o), 4);
    chk("nm cpld", int'(cpld_avail_o), 122);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("nm full%0d", i), int'(rd_gnt_o), 0);
    end
    rd_req_i = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
